// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and helpers for the multi-channel debouncer.
//   pb_state_e : per-channel event FSM state (REL, PRESS, LONG).
//   cnt_width  : counter width for a count range, $clog2 with a floor of 1.
//   max_int    : larger of two integers, used to size the shared hold counter.
package debounce_pkg;

  typedef enum logic [1:0] {
    REL   = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } pb_state_e;

  function automatic int cnt_width(input int max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one button channel -- optional inversion, 2-flop synchroniser,
// persistence filter and press/long/repeat event FSM.
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset
//   push_btn    : raw asynchronous pin
//   pb_stbl     : debounced level, 1 = pressed
//   pb_rise     : one-cycle pulse on accepted press
//   pb_fall     : one-cycle pulse on accepted release
//   pb_long     : one-cycle long-press / auto-repeat pulse
//   dbg_state   : current event FSM state
// All event outputs are registered single-cycle pulses; there is no handshake,
// a consumer must sample them every cycle.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CNT_VAL    = 500_000,
  parameter int LONG_VAL   = 50_000_000,
  parameter bit REPEAT_EN  = 1'b1,
  parameter int REPEAT_VAL = 10_000_000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic      clk,
  input  logic      arst_n,
  input  logic      push_btn,
  output logic      pb_stbl,
  output logic      pb_rise,
  output logic      pb_fall,
  output logic      pb_long,
  output pb_state_e dbg_state
);

  localparam int CW = cnt_width(CNT_VAL);
  localparam int HW = cnt_width(max_int(LONG_VAL, REPEAT_VAL));
  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_VAL - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_VAL - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_VAL - 1);

  logic          pin_in;
  logic          sync1_q, sync1_d;
  logic          samp_q, samp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stbl_q, stbl_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          long_q, long_d;
  logic [HW-1:0] hold_q, hold_d;
  pb_state_e     state_q, state_d;
  logic          accept;

  // Inversion happens before the synchroniser so reset value 0 means "released".
  assign pin_in = push_btn ^ ACTIVE_LOW;

  always_comb begin
    sync1_d = pin_in;
    samp_d  = sync1_q;

    // Filter: a differing level must persist CNT_VAL cycles; any agreement restarts.
    accept = 1'b0;
    cnt_d  = cnt_q;
    stbl_d = stbl_q;
    if (samp_q == stbl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      accept = 1'b1;
      cnt_d  = '0;
      stbl_d = samp_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    rise_d = accept & samp_q;
    fall_d = accept & ~samp_q;

    // Event FSM. A release overrides everything, including a pb_long due now.
    state_d = state_q;
    hold_d  = hold_q;
    long_d  = 1'b0;
    if (fall_d) begin
      state_d = REL;
      hold_d  = '0;
    end else begin
      case (state_q)
        REL: begin
          hold_d = '0;
          if (rise_d) state_d = PRESS;
        end
        PRESS: begin
          if (hold_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = LONG;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        LONG: begin
          // Without repeat the hold counter stays frozen until release.
          if (REPEAT_EN) begin
            if (hold_q == REP_LAST) begin
              long_d = 1'b1;
              hold_d = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = REL;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1_q <= 1'b0;
      samp_q  <= 1'b0;
      cnt_q   <= '0;
      stbl_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
      hold_q  <= '0;
      state_q <= REL;
    end else begin
      sync1_q <= sync1_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      stbl_q  <= stbl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
      hold_q  <= hold_d;
      state_q <= state_d;
    end
  end

  assign pb_stbl   = stbl_q;
  assign pb_rise   = rise_q;
  assign pb_fall   = fall_q;
  assign pb_long   = long_q;
  assign dbg_state = state_q;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: NUM_CH independent push-button debouncers with event pulses.
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset
//   push_btn    : NUM_CH raw asynchronous button pins
//   pb_stbl     : debounced levels, 1 = pressed
//   pb_rise     : one-cycle pulses on accepted press
//   pb_fall     : one-cycle pulses on accepted release
//   pb_long     : one-cycle long-press / auto-repeat pulses
// Per-channel FSM state is available at gen_ch[i].u_ch.dbg_state.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_VAL    = 500_000,
  parameter int LONG_VAL   = 50_000_000,
  parameter bit REPEAT_EN  = 1'b1,
  parameter int REPEAT_VAL = 10_000_000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [NUM_CH-1:0] push_btn,
  output logic [NUM_CH-1:0] pb_stbl,
  output logic [NUM_CH-1:0] pb_rise,
  output logic [NUM_CH-1:0] pb_fall,
  output logic [NUM_CH-1:0] pb_long
);

  // State taps are not part of the pin interface; they exist for probing only.
  pb_state_e dbg_state_unused [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    debounce_ch #(
      .CNT_VAL   (CNT_VAL),
      .LONG_VAL  (LONG_VAL),
      .REPEAT_EN (REPEAT_EN),
      .REPEAT_VAL(REPEAT_VAL),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .arst_n   (arst_n),
      .push_btn (push_btn[i]),
      .pb_stbl  (pb_stbl[i]),
      .pb_rise  (pb_rise[i]),
      .pb_fall  (pb_fall[i]),
      .pb_long  (pb_long[i]),
      .dbg_state(dbg_state_unused[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: three instances (repeat on, repeat off, active-low),
// directed stimulus, expected pulses queued with their cycle, monitor compares.
module tb_debounce_multi;
  import debounce_pkg::*;

  localparam logic [2:0] K_RISE = 3'b100;
  localparam logic [2:0] K_FALL = 3'b010;
  localparam logic [2:0] K_LONG = 3'b001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] btn [3];
  logic [1:0] stbl[3];
  logic [1:0] rise[3];
  logic [1:0] fall[3];
  logic [1:0] lng [3];

  debounce_multi #(.NUM_CH(2), .CNT_VAL(4), .LONG_VAL(16), .REPEAT_EN(1'b1),
                   .REPEAT_VAL(8), .ACTIVE_LOW(1'b0)) dut_main (
    .clk(clk), .arst_n(arst_n), .push_btn(btn[0]), .pb_stbl(stbl[0]),
    .pb_rise(rise[0]), .pb_fall(fall[0]), .pb_long(lng[0]));

  debounce_multi #(.NUM_CH(2), .CNT_VAL(4), .LONG_VAL(16), .REPEAT_EN(1'b0),
                   .REPEAT_VAL(8), .ACTIVE_LOW(1'b0)) dut_norep (
    .clk(clk), .arst_n(arst_n), .push_btn(btn[1]), .pb_stbl(stbl[1]),
    .pb_rise(rise[1]), .pb_fall(fall[1]), .pb_long(lng[1]));

  debounce_multi #(.NUM_CH(2), .CNT_VAL(4), .LONG_VAL(16), .REPEAT_EN(1'b1),
                   .REPEAT_VAL(8), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .arst_n(arst_n), .push_btn(btn[2]), .pb_stbl(stbl[2]),
    .pb_rise(rise[2]), .pb_fall(fall[2]), .pb_long(lng[2]));

  // ---------------- scoreboard ----------------
  // entry: {inst[1:0], cycle[15:0], ch, kind[2:0]}
  logic [21:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic exp_ev(input int inst, input int at, input int ch, input logic [2:0] kind);
    logic [1:0]  i2;
    logic [15:0] a16;
    logic        c1;
    i2  = inst[1:0];
    a16 = at[15:0];
    c1  = ch[0];
    exp_q.push_back({i2, a16, c1, kind});
  endtask

  task automatic chk_all_zero(input int inst, input string name);
    chk({name, "_stbl"}, 32'(stbl[inst]), 0);
    chk({name, "_rise"}, 32'(rise[inst]), 0);
    chk({name, "_fall"}, 32'(fall[inst]), 0);
    chk({name, "_long"}, 32'(lng[inst]), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [2:0]  k;
    logic [21:0] act;
    logic [21:0] e;
    logic [1:0]  i2;
    logic        c1;
    for (int n = 0; n < 3; n++) begin
      for (int c = 0; c < 2; c++) begin
        k = {rise[n][c], fall[n][c], lng[n][c]};
        if (k != 3'b000) begin
          i2  = n[1:0];
          c1  = c[0];
          act = {i2, cyc[15:0], c1, k};
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event_unexpected: got inst=%0d cyc=%0d ch=%0d kind=%b, required no event",
                     act[21:20], act[19:4], act[3], act[2:0]);
          end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
              failures++;
              $display("FAIL event: got inst=%0d cyc=%0d ch=%0d kind=%b, required inst=%0d cyc=%0d ch=%0d kind=%b",
                       act[21:20], act[19:4], act[3], act[2:0], e[21:20], e[19:4], e[3], e[2:0]);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int t;
    int r;
    arst_n = 1'b0;
    btn[0] = 2'b00;
    btn[1] = 2'b00;
    btn[2] = 2'b11;
    repeat (3) @(negedge clk);
    chk_all_zero(0, "rst_main");
    chk_all_zero(1, "rst_norep");
    chk_all_zero(2, "rst_al");
    chk("rst_state", 32'(dut_main.gen_ch[0].u_ch.dbg_state), 32'(REL));
    arst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("al_idle_stbl", 32'(stbl[2]), 0);

    // Clean press on ch0 held 40 cycles; release lands on a pb_long cycle.
    t = cyc;
    btn[0][0] = 1'b1;
    exp_ev(0, t + 6,  0, K_RISE);
    exp_ev(0, t + 22, 0, K_LONG);
    exp_ev(0, t + 30, 0, K_LONG);
    exp_ev(0, t + 38, 0, K_LONG);
    exp_ev(0, t + 46, 0, K_FALL);
    repeat (5) @(negedge clk);
    chk("s1_stbl_edge5", 32'(stbl[0][0]), 0);
    @(negedge clk);
    chk("s1_stbl_edge6", 32'(stbl[0][0]), 1);
    chk("s1_ch1_stbl", 32'(stbl[0][1]), 0);
    repeat (33) @(negedge clk);
    chk("s1_state_long", 32'(dut_main.gen_ch[0].u_ch.dbg_state), 32'(LONG));
    @(negedge clk);
    btn[0][0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("s3_long_cancelled", 32'(lng[0][0]), 0);
    chk("s3_fall_pulse", 32'(fall[0][0]), 1);
    chk("s3_state_rel", 32'(dut_main.gen_ch[0].u_ch.dbg_state), 32'(REL));
    repeat (10) @(negedge clk);

    // Long press on ch1 then release one cycle after a repeat pulse.
    t = cyc;
    btn[0][1] = 1'b1;
    exp_ev(0, t + 6,  1, K_RISE);
    exp_ev(0, t + 22, 1, K_LONG);
    exp_ev(0, t + 30, 1, K_LONG);
    exp_ev(0, t + 31, 1, K_FALL);
    repeat (25) @(negedge clk);
    btn[0][1] = 1'b0;
    repeat (6) @(negedge clk);
    chk("s3a_state_rel", 32'(dut_main.gen_ch[1].u_ch.dbg_state), 32'(REL));
    chk("s3a_stbl", 32'(stbl[0][1]), 0);
    repeat (10) @(negedge clk);

    // Bounce 1,0,1,1,0 then held high.
    t = cyc;
    btn[0][0] = 1'b1; @(negedge clk);
    btn[0][0] = 1'b0; @(negedge clk);
    btn[0][0] = 1'b1; @(negedge clk);
    @(negedge clk);
    btn[0][0] = 1'b0; @(negedge clk);
    btn[0][0] = 1'b1;
    exp_ev(0, t + 11, 0, K_RISE);
    exp_ev(0, t + 21, 0, K_FALL);
    repeat (5) @(negedge clk);
    chk("s2_stbl_before", 32'(stbl[0][0]), 0);
    @(negedge clk);
    chk("s2_stbl_after", 32'(stbl[0][0]), 1);
    repeat (4) @(negedge clk);
    btn[0][0] = 1'b0;
    repeat (16) @(negedge clk);

    // REPEAT_EN=0: one pb_long only.
    t = cyc;
    btn[1][0] = 1'b1;
    exp_ev(1, t + 6,  0, K_RISE);
    exp_ev(1, t + 22, 0, K_LONG);
    exp_ev(1, t + 66, 0, K_FALL);
    repeat (60) @(negedge clk);
    chk("s4_state_long", 32'(dut_norep.gen_ch[0].u_ch.dbg_state), 32'(LONG));
    btn[1][0] = 1'b0;
    repeat (16) @(negedge clk);

    // ACTIVE_LOW=1: pin pulled low is a press.
    t = cyc;
    btn[2][0] = 1'b0;
    exp_ev(2, t + 6,  0, K_RISE);
    exp_ev(2, t + 16, 0, K_FALL);
    repeat (5) @(negedge clk);
    chk("s5_stbl_edge5", 32'(stbl[2][0]), 0);
    @(negedge clk);
    chk("s5_stbl_edge6", 32'(stbl[2][0]), 1);
    repeat (4) @(negedge clk);
    btn[2][0] = 1'b1;
    repeat (16) @(negedge clk);

    // Reset mid-count on ch1, button held through reset release.
    t = cyc;
    btn[0][1] = 1'b1;
    repeat (3) @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk_all_zero(0, "s6a_rst");
    repeat (2) @(negedge clk);
    r = cyc;
    exp_ev(0, r + 6,  1, K_RISE);
    exp_ev(0, r + 16, 1, K_FALL);
    arst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("s6a_stbl_edge5", 32'(stbl[0][1]), 0);
    @(negedge clk);
    chk("s6a_stbl_edge6", 32'(stbl[0][1]), 1);
    repeat (4) @(negedge clk);
    btn[0][1] = 1'b0;
    repeat (16) @(negedge clk);

    // Reset while ch0 is in LONG.
    t = cyc;
    btn[0][0] = 1'b1;
    exp_ev(0, t + 6,  0, K_RISE);
    exp_ev(0, t + 22, 0, K_LONG);
    repeat (26) @(negedge clk);
    chk("s6b_stbl_pre", 32'(stbl[0][0]), 1);
    arst_n = 1'b0;
    #1;
    chk_all_zero(0, "s6b_rst");
    chk("s6b_state_rel", 32'(dut_main.gen_ch[0].u_ch.dbg_state), 32'(REL));
    repeat (3) @(negedge clk);
    r = cyc;
    exp_ev(0, r + 6,  0, K_RISE);
    exp_ev(0, r + 16, 0, K_FALL);
    arst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("s6b_stbl_edge6", 32'(stbl[0][0]), 1);
    repeat (4) @(negedge clk);
    btn[0][0] = 1'b0;
    repeat (20) @(negedge clk);

    // ---------------- report ----------------
    while (exp_q.size() != 0) begin
      logic [21:0] e;
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL event_missing: got nothing, required inst=%0d cyc=%0d ch=%0d kind=%b",
               e[21:20], e[19:4], e[3], e[2:0]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
